// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   owner_t   : which master (if any) owns the read response in flight
//   mem_req_t : one master's request payload (we, byte address, lanes, data)
//   DMEM_*    : default DMEM window and arbitration constants
package dmem_arb_pkg;

  localparam logic [31:0] DMEM_BASE_ADDR  = 32'h0001_0000;
  localparam int          DMEM_SIZE       = 4096;
  localparam int          DMEM_AW         = 12;
  localparam int          DMEM_MAX_M0_RUN = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  typedef struct packed {
    logic        we;
    logic [31:0] add;
    logic [3:0]  ble;
    logic [31:0] di;
  } mem_req_t;

endpackage

// File: rtl/dmem_arb_addr_dec.sv
// DMEM window decoder for one master.
//   add_i      : byte address from the master
//   hit_o      : 1 when BASE_ADDR <= add_i < BASE_ADDR + SIZE
//   word_add_o : memory word address, add_i[AW+1:2]
module dmem_arb_addr_dec #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          SIZE      = 4096,
  parameter int          AW        = 12
) (
  input  logic [31:0]   add_i,
  output logic          hit_o,
  output logic [AW-1:0] word_add_o
);

  // Compare in 33 bits so a window ending at 4 GiB does not wrap.
  localparam logic [32:0] LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI = LO + 33'(SIZE);

  logic [32:0] add_ext;

  assign add_ext    = {1'b0, add_i};
  assign hit_o      = (add_ext >= LO) && (add_ext < HI);
  assign word_add_o = add_i[AW+1:2];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-port synchronous-read DMEM.
//   m0_* : RV32i core data port (priority master)
//   m1_* : loader / debug DMA
//   mem_*: memory side (read data arrives the cycle after mem_re_o)
//   dbg_owner_o, dbg_run_cnt_o : internal state for checkers
//
// Handshake: a master raises mX_req_i with its payload and holds both stable
// until mX_gnt_o=1 in the same cycle; that cycle is the transfer. A read
// returns exactly one mX_rvalid_o pulse on the following cycle; writes return
// nothing. Dropping a request without a grant is harmless.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DMEM_BASE_ADDR,
  parameter int          SIZE       = DMEM_SIZE,
  parameter int          AW         = DMEM_AW,
  parameter int          MAX_M0_RUN = DMEM_MAX_M0_RUN
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                m0_req_i,
  input  logic                                m0_we_i,
  input  logic [31:0]                         m0_add_i,
  input  logic [3:0]                          m0_ble_i,
  input  logic [31:0]                         m0_di_i,
  output logic                                m0_gnt_o,
  output logic                                m0_rvalid_o,
  output logic [31:0]                         m0_do_o,
  input  logic                                m1_req_i,
  input  logic                                m1_we_i,
  input  logic [31:0]                         m1_add_i,
  input  logic [3:0]                          m1_ble_i,
  input  logic [31:0]                         m1_di_i,
  output logic                                m1_gnt_o,
  output logic                                m1_rvalid_o,
  output logic [31:0]                         m1_do_o,
  output logic                                mem_re_o,
  output logic                                mem_we_o,
  output logic [3:0]                          mem_ble_o,
  output logic [AW-1:0]                       mem_add_o,
  output logic [31:0]                         mem_di_o,
  input  logic [31:0]                         mem_do_i,
  output owner_t                              dbg_owner_o,
  output logic [$clog2(MAX_M0_RUN+1)-1:0]     dbg_run_cnt_o
);

  localparam int            CW      = $clog2(MAX_M0_RUN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(MAX_M0_RUN);

  mem_req_t      m0_r, m1_r, sel_r;
  logic          m0_hit, m1_hit, sel_hit;
  logic [AW-1:0] m0_wadd, m1_wadd;
  logic          m0_win, m1_win, any_win;

  logic [CW-1:0] run_cnt_q;
  owner_t        owner_q;
  logic          miss_q;

  assign m0_r = '{we: m0_we_i, add: m0_add_i, ble: m0_ble_i, di: m0_di_i};
  assign m1_r = '{we: m1_we_i, add: m1_add_i, ble: m1_ble_i, di: m1_di_i};

  dmem_arb_addr_dec #(.BASE_ADDR(BASE_ADDR), .SIZE(SIZE), .AW(AW)) u_dec_m0 (
    .add_i      (m0_r.add),
    .hit_o      (m0_hit),
    .word_add_o (m0_wadd)
  );

  dmem_arb_addr_dec #(.BASE_ADDR(BASE_ADDR), .SIZE(SIZE), .AW(AW)) u_dec_m1 (
    .add_i      (m1_r.add),
    .hit_o      (m1_hit),
    .word_add_o (m1_wadd)
  );

  // M1 wins when M0 is idle or M0 has used up its run budget while M1 waited.
  assign m1_win  = ~rst_i & m1_req_i & (~m0_req_i | (run_cnt_q == RUN_MAX));
  assign m0_win  = ~rst_i & m0_req_i & ~m1_win;
  assign any_win = m0_win | m1_win;

  assign m0_gnt_o = m0_win;
  assign m1_gnt_o = m1_win;

  assign sel_r   = m1_win ? m1_r : m0_r;
  assign sel_hit = m1_win ? m1_hit : m0_hit;

  // A granted miss is still accepted (no stall) but never touches memory.
  assign mem_re_o  = any_win & sel_hit & ~sel_r.we;
  assign mem_we_o  = any_win & sel_hit & sel_r.we;
  assign mem_ble_o = mem_we_o ? sel_r.ble : 4'b0000;
  assign mem_add_o = m1_win ? m1_wadd : m0_wadd;
  assign mem_di_o  = sel_r.di;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_cnt_q <= '0;
      owner_q   <= OWN_NONE;
      miss_q    <= 1'b0;
    end else begin
      if (m1_win || !m1_req_i) begin
        run_cnt_q <= '0;
      end else if (m0_win && run_cnt_q != RUN_MAX) begin
        run_cnt_q <= run_cnt_q + 1'b1;
      end

      if (any_win && !sel_r.we) begin
        owner_q <= m1_win ? OWN_M1 : OWN_M0;
        miss_q  <= ~sel_hit;
      end else begin
        owner_q <= OWN_NONE;
        miss_q  <= 1'b0;
      end
    end
  end

  // Gated by rst_i so a read granted just before reset never reports back.
  assign m0_rvalid_o = ~rst_i & (owner_q == OWN_M0);
  assign m1_rvalid_o = ~rst_i & (owner_q == OWN_M1);
  assign m0_do_o     = (m0_rvalid_o && !miss_q) ? mem_do_i : 32'h0;
  assign m1_do_o     = (m1_rvalid_o && !miss_q) ? mem_do_i : 32'h0;

  assign dbg_owner_o   = owner_q;
  assign dbg_run_cnt_o = run_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [31:0] m0_add_i, m0_di_i, m1_add_i, m1_di_i;
  logic [3:0]  m0_ble_i, m1_ble_i;
  logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [31:0] m0_do_o, m1_do_o;
  logic        mem_re_o, mem_we_o;
  logic [3:0]  mem_ble_o;
  logic [11:0] mem_add_o;
  logic [31:0] mem_di_o;
  logic [31:0] mem_do_i;
  owner_t      dbg_owner_o;
  logic [2:0]  dbg_run_cnt_o;

  int n_chk = 0;
  int n_bad = 0;

  // Expected response owner per granted read (0 = M0, 1 = M1).
  logic [1:0] exp_q[$];

  dmem_arbiter dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .m0_req_i      (m0_req_i),
    .m0_we_i       (m0_we_i),
    .m0_add_i      (m0_add_i),
    .m0_ble_i      (m0_ble_i),
    .m0_di_i       (m0_di_i),
    .m0_gnt_o      (m0_gnt_o),
    .m0_rvalid_o   (m0_rvalid_o),
    .m0_do_o       (m0_do_o),
    .m1_req_i      (m1_req_i),
    .m1_we_i       (m1_we_i),
    .m1_add_i      (m1_add_i),
    .m1_ble_i      (m1_ble_i),
    .m1_di_i       (m1_di_i),
    .m1_gnt_o      (m1_gnt_o),
    .m1_rvalid_o   (m1_rvalid_o),
    .m1_do_o       (m1_do_o),
    .mem_re_o      (mem_re_o),
    .mem_we_o      (mem_we_o),
    .mem_ble_o     (mem_ble_o),
    .mem_add_o     (mem_add_o),
    .mem_di_o      (mem_di_o),
    .mem_do_i      (mem_do_i),
    .dbg_owner_o   (dbg_owner_o),
    .dbg_run_cnt_o (dbg_run_cnt_o)
  );

  // Clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge; checks follow #1 later.
  task automatic set_m0(input logic req, input logic we, input logic [31:0] add,
                        input logic [3:0] ble, input logic [31:0] di);
    m0_req_i = req; m0_we_i = we; m0_add_i = add; m0_ble_i = ble; m0_di_i = di;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [31:0] add,
                        input logic [3:0] ble, input logic [31:0] di);
    m1_req_i = req; m1_we_i = we; m1_add_i = add; m1_ble_i = ble; m1_di_i = di;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  logic [1:0]  who;
  logic [31:0] rd;

  initial begin
    rst_i = 1'b1;
    mem_do_i = 32'h0;
    set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk_i);

    // Reset held with both masters requesting: nothing is granted.
    set_m0(1'b1, 1'b0, 32'h0001_0000, 4'hF, 32'h0);
    set_m1(1'b1, 1'b0, 32'h0001_0004, 4'hF, 32'h0);
    next_cycle();
    #1;
    check("rst_m0_gnt", m0_gnt_o, 0);
    check("rst_m1_gnt", m1_gnt_o, 0);
    check("rst_mem_re", mem_re_o, 0);
    check("rst_mem_we", mem_we_o, 0);
    check("rst_rvalid", {m0_rvalid_o, m1_rvalid_o}, 0);
    check("rst_owner", dbg_owner_o, OWN_NONE);
    check("rst_run_cnt", dbg_run_cnt_o, 0);

    // Release: M0 wins on priority straight away.
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rel_m0_gnt", m0_gnt_o, 1);
    check("rel_m1_gnt", m1_gnt_o, 0);
    check("rel_mem_add", mem_add_o, 32'h0);
    next_cycle();
    set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    mem_do_i = 32'h1111_2222;
    #1;
    check("rel_m0_rvalid", m0_rvalid_o, 1);
    check("rel_m0_do", m0_do_o, 32'h1111_2222);
    check("rel_m1_rvalid", m1_rvalid_o, 0);

    // M0 read alone at 0x0001_0010.
    next_cycle();
    set_m0(1'b1, 1'b0, 32'h0001_0010, 4'hF, 32'hDEAD_BEEF);
    #1;
    check("rd_m0_gnt", m0_gnt_o, 1);
    check("rd_m1_gnt", m1_gnt_o, 0);
    check("rd_mem_re", mem_re_o, 1);
    check("rd_mem_we", mem_we_o, 0);
    check("rd_mem_ble", mem_ble_o, 0);
    check("rd_mem_add", mem_add_o, 32'd4);
    next_cycle();
    set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    mem_do_i = 32'hA5A5_1234;
    #1;
    check("rd_m0_rvalid", m0_rvalid_o, 1);
    check("rd_m0_do", m0_do_o, 32'hA5A5_1234);
    check("rd_m1_rvalid", m1_rvalid_o, 0);
    check("rd_m1_do", m1_do_o, 0);

    // Both request every cycle: M0 x4 then M1, repeating; responses routed back.
    next_cycle();
    set_m0(1'b1, 1'b0, 32'h0001_0020, 4'h0, 32'h0);
    set_m1(1'b1, 1'b0, 32'h0001_0040, 4'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      mem_do_i = 32'hC000_0000 + 32'(i);
      #1;
      if (exp_q.size() > 0) begin
        who = exp_q.pop_front();
        check("rr_m0_rvalid", m0_rvalid_o, (who == 2'd0));
        check("rr_m1_rvalid", m1_rvalid_o, (who == 2'd1));
        rd = (who == 2'd0) ? m0_do_o : m1_do_o;
        check("rr_do", rd, 32'hC000_0000 + 32'(i));
      end
      check("rr_m0_gnt", m0_gnt_o, (i % 5 != 4));
      check("rr_m1_gnt", m1_gnt_o, (i % 5 == 4));
      check("rr_mem_add", mem_add_o, (i % 5 == 4) ? 32'h10 : 32'h8);
      exp_q.push_back((i % 5 == 4) ? 2'd1 : 2'd0);
      next_cycle();
    end
    set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    mem_do_i = 32'h0BAD_F00D;
    #1;
    who = exp_q.pop_front();
    check("rr_last_m1_rvalid", m1_rvalid_o, (who == 2'd1));
    check("rr_last_m1_do", m1_do_o, 32'h0BAD_F00D);

    // M1 write at the top word of the window.
    next_cycle();
    set_m1(1'b1, 1'b1, 32'h0001_0FFC, 4'b0011, 32'h1234_5678);
    #1;
    check("wr_m1_gnt", m1_gnt_o, 1);
    check("wr_mem_we", mem_we_o, 1);
    check("wr_mem_re", mem_re_o, 0);
    check("wr_mem_add", mem_add_o, 32'h3FF);
    check("wr_mem_ble", mem_ble_o, 32'b0011);
    check("wr_mem_di", mem_di_o, 32'h1234_5678);
    next_cycle();
    set_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    check("wr_no_rvalid", {m0_rvalid_o, m1_rvalid_o}, 0);

    // M0 read that misses the window: granted, no memory access, zero data.
    next_cycle();
    set_m0(1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
    #1;
    check("miss_gnt", m0_gnt_o, 1);
    check("miss_mem_re", mem_re_o, 0);
    check("miss_mem_we", mem_we_o, 0);
    next_cycle();
    set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    mem_do_i = 32'hFFFF_FFFF;
    #1;
    check("miss_rvalid", m0_rvalid_o, 1);
    check("miss_do", m0_do_o, 0);

    // Window edges: last byte hits, one past the end and one below miss.
    next_cycle();
    set_m0(1'b1, 1'b0, 32'h0001_0FFF, 4'h0, 32'h0);
    #1;
    check("edge_last_re", mem_re_o, 1);
    m0_add_i = 32'h0001_1000;
    #1;
    check("edge_end_re", mem_re_o, 0);
    m0_add_i = 32'h0000_FFFC;
    #1;
    check("edge_below_re", mem_re_o, 0);
    m0_we_i = 1'b1;
    m0_ble_i = 4'hA;
    #1;
    check("edge_below_we", mem_we_o, 0);
    check("edge_below_ble", mem_ble_o, 0);

    // Reset arriving while a read response is pending.
    next_cycle();
    set_m0(1'b1, 1'b0, 32'h0001_0008, 4'h0, 32'h0);
    #1;
    check("rstrd_gnt", m0_gnt_o, 1);
    next_cycle();
    set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst_i = 1'b1;
    mem_do_i = 32'h5555_AAAA;
    #1;
    check("rstrd_rvalid", m0_rvalid_o, 0);
    check("rstrd_do", m0_do_o, 0);
    next_cycle();
    rst_i = 1'b0;
    #1;
    check("rstrd_after_rvalid", m0_rvalid_o, 0);
    check("rstrd_owner", dbg_owner_o, OWN_NONE);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
